// File: rtl/niosii_top_led_fader_pkg.sv
// Shared types and defaults for the LED fader.
// Per-channel state encoding: OFF=0, RISE=1, ON=2, FALL=3.
package niosii_top_led_fader_pkg;

    localparam int unsigned DEF_N_LED    = 10;
    localparam int unsigned DEF_PWM_BITS = 8;
    localparam int unsigned DEF_STEP_DIV = 1024;

    typedef enum logic [1:0] {
        LF_OFF  = 2'd0,
        LF_RISE = 2'd1,
        LF_ON   = 2'd2,
        LF_FALL = 2'd3
    } lf_state_e;

endpackage

// File: rtl/niosii_top_led_fader_chan.sv
// One fader channel: brightness level, ramp state, duty mapping and PWM compare flop.
// LED_FADER_GAMMA_EN selects the quadratic duty curve instead of the linear one.
module niosii_top_led_fader_chan
    import niosii_top_led_fader_pkg::*;
#(
    parameter int unsigned PWM_BITS = DEF_PWM_BITS
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                step_tick,
    input  logic                target,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                led,
    output logic                ramping
);

    localparam logic [PWM_BITS-1:0] LVL_MAX = '1;
    localparam logic [PWM_BITS-1:0] ONE     = PWM_BITS'(1);

    logic [PWM_BITS-1:0] level;
    logic [PWM_BITS-1:0] duty;
    lf_state_e           state;
    lf_state_e           state_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level <= '0;
        end else if (step_tick) begin
            if (target && level != LVL_MAX) begin
                level <= level + ONE;
            end else if (!target && level != '0) begin
                level <= level - ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= LF_OFF;
        end else begin
            state <= state_next;
        end
    end

    // Resolving each cycle from (target, level) covers entry, completion and
    // mid-ramp reversal alike; the level itself never jumps.
    always_comb begin
        state_next = state;
        if (target && level == LVL_MAX) begin
            state_next = LF_ON;
        end else if (!target && level == '0) begin
            state_next = LF_OFF;
        end else if (target) begin
            state_next = LF_RISE;
        end else begin
            state_next = LF_FALL;
        end
    end

    always_comb begin
        ramping = (state == LF_RISE) || (state == LF_FALL);
    end

`ifdef LED_FADER_GAMMA_EN
    logic [2*PWM_BITS-1:0] level_sq;

    always_comb begin
        level_sq = {{PWM_BITS{1'b0}}, level} * ({{PWM_BITS{1'b0}}, level} + (2*PWM_BITS)'(1));
        duty     = level_sq[2*PWM_BITS-1:PWM_BITS];
    end
`else
    always_comb begin
        duty = level;
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            led <= 1'b0;
        end else begin
            led <= (pwm_cnt < duty);
        end
    end

endmodule

// File: rtl/niosii_top_led_fader.sv
// PIO-driven LED fader: input register, shared step prescaler and PWM counter, busy flag.
// Define LED_FADER_GAMMA_EN for the quadratic brightness curve (linear by default).
module niosii_top_led_fader
    import niosii_top_led_fader_pkg::*;
#(
    parameter int unsigned N_LED    = DEF_N_LED,
    parameter int unsigned PWM_BITS = DEF_PWM_BITS,
    parameter int unsigned STEP_DIV = DEF_STEP_DIV
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_LED-1:0] pio_in,
    output logic [N_LED-1:0] led,
    output logic             busy
);

    localparam int unsigned         PS_W     = $clog2(STEP_DIV);
    localparam logic [PS_W-1:0]     PS_LAST  = PS_W'(STEP_DIV - 1);
    localparam logic [PS_W-1:0]     PS_ONE   = PS_W'(1);
    localparam logic [PWM_BITS-1:0] PWM_LAST = PWM_BITS'((2**PWM_BITS) - 2);
    localparam logic [PWM_BITS-1:0] PWM_ONE  = PWM_BITS'(1);

    logic [N_LED-1:0]    pio_q;
    logic [PS_W-1:0]     prescaler;
    logic                step_tick;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [N_LED-1:0]    ramping;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pio_q <= '0;
        end else begin
            pio_q <= pio_in;
        end
    end

    always_comb begin
        step_tick = (prescaler == PS_LAST);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prescaler <= '0;
        end else if (step_tick) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + PS_ONE;
        end
    end

    // PWM period is LVL_MAX cycles so that a full-scale duty is a solid 1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_cnt <= '0;
        end else if (pwm_cnt == PWM_LAST) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_ONE;
        end
    end

    for (genvar i = 0; i < N_LED; i++) begin : g_chan
        niosii_top_led_fader_chan #(
            .PWM_BITS (PWM_BITS)
        ) u_chan (
            .clk       (clk),
            .reset_n   (reset_n),
            .step_tick (step_tick),
            .target    (pio_q[i]),
            .pwm_cnt   (pwm_cnt),
            .led       (led[i]),
            .ramping   (ramping[i])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy <= 1'b0;
        end else begin
            busy <= |ramping;
        end
    end

endmodule

// File: tb/tb_niosii_top_led_fader.sv
// Self-checking bench for niosii_top_led_fader (N_LED=10, PWM_BITS=4, STEP_DIV=4).
// Honours LED_FADER_GAMMA_EN in its reference model and forced-level expectations.
module tb_niosii_top_led_fader;

    localparam int N    = 10;
    localparam int PB   = 4;
    localparam int LMAX = 15;
    localparam int SD   = 4;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [N-1:0] pio_in;
    logic [N-1:0] led;
    logic         busy;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    int           m_level [N];
    logic [N-1:0] m_pq;
    bit           m_ramp  [N];
    int           m_presc;
    int           m_pwm;
    logic [N-1:0] m_led;
    bit           m_busy;

    typedef struct {
        logic [N-1:0] pat;
        int           hold;
        logic [N-1:0] exp_led;
        bit           exp_busy;
    } vec_t;

    typedef struct {
        logic [3:0] lvl;
        int         exp_high;
    } force_vec_t;

    vec_t       vecs [6];
    force_vec_t fvecs [4];

    niosii_top_led_fader #(
        .N_LED    (N),
        .PWM_BITS (PB),
        .STEP_DIV (SD)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .pio_in  (pio_in),
        .led     (led),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    function automatic int duty_of(input int lv);
`ifdef LED_FADER_GAMMA_EN
        return (lv * (lv + 1)) / (2 ** PB);
`else
        return lv;
`endif
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_level[i] = 0;
            m_ramp[i]  = 0;
        end
        m_pq    = '0;
        m_presc = 0;
        m_pwm   = 0;
        m_led   = '0;
        m_busy  = 0;
    endtask

    // One clock of the spec's behaviour, all from pre-edge values.
    task automatic model_step();
        bit           tick;
        logic [N-1:0] nl;
        bit           nb;
        int           nlev  [N];
        bit           nramp [N];
        tick = (m_presc == SD - 1);
        nb   = 0;
        for (int i = 0; i < N; i++) begin
            nl[i]    = (m_pwm < duty_of(m_level[i]));
            nb       = nb | m_ramp[i];
            nramp[i] = !((m_pq[i] && m_level[i] == LMAX) || (!m_pq[i] && m_level[i] == 0));
            nlev[i]  = m_level[i];
            if (tick) begin
                if (m_pq[i] && m_level[i] < LMAX) nlev[i] = m_level[i] + 1;
                else if (!m_pq[i] && m_level[i] > 0) nlev[i] = m_level[i] - 1;
            end
        end
        for (int i = 0; i < N; i++) begin
            m_level[i] = nlev[i];
            m_ramp[i]  = nramp[i];
        end
        m_led   = nl;
        m_busy  = nb;
        m_pq    = pio_in;
        m_presc = (m_presc + 1) % SD;
        m_pwm   = (m_pwm + 1) % LMAX;
    endtask

    task automatic cycle(input bit do_chk);
        @(posedge clk);
        model_step();
        #1;
        if (do_chk) begin
            chk("led", int'(led), int'(m_led));
            chk("busy", int'(busy), int'(m_busy));
            chk("level0", int'(dut.g_chan[0].u_chan.level), m_level[0]);
            chk("level9", int'(dut.g_chan[9].u_chan.level), m_level[9]);
        end
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        #1;
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        int  cnt;
        bit  seen;

        vecs[0] = '{pat: 10'h3FF, hold: 80, exp_led: 10'h3FF, exp_busy: 1'b0};
        vecs[1] = '{pat: 10'h000, hold: 80, exp_led: 10'h000, exp_busy: 1'b0};
        vecs[2] = '{pat: 10'h2AA, hold: 80, exp_led: 10'h2AA, exp_busy: 1'b0};
        vecs[3] = '{pat: 10'h155, hold: 80, exp_led: 10'h155, exp_busy: 1'b0};
        vecs[4] = '{pat: 10'h201, hold: 80, exp_led: 10'h201, exp_busy: 1'b0};
        vecs[5] = '{pat: 10'h000, hold: 80, exp_led: 10'h000, exp_busy: 1'b0};

`ifdef LED_FADER_GAMMA_EN
        fvecs[0] = '{lvl: 4'd15, exp_high: 15};
        fvecs[1] = '{lvl: 4'd1,  exp_high: 0};
        fvecs[2] = '{lvl: 4'd7,  exp_high: 3};
        fvecs[3] = '{lvl: 4'd5,  exp_high: 1};
`else
        fvecs[0] = '{lvl: 4'd15, exp_high: 15};
        fvecs[1] = '{lvl: 4'd1,  exp_high: 1};
        fvecs[2] = '{lvl: 4'd7,  exp_high: 7};
        fvecs[3] = '{lvl: 4'd5,  exp_high: 5};
`endif

        // Power-on reset
        reset_n = 1'b0;
        pio_in  = '0;
        model_reset();
        #1;
        chk("por_led", int'(led), 0);
        chk("por_busy", int'(busy), 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Single channel rise
        pio_in = 10'h001;
        seen = 0;
        for (int c = 0; c < 4 && !seen; c++) begin
            cycle(1);
            if (busy) seen = 1;
        end
        chk("busy_rise_timeout", int'(seen), 1);
        seen = 0;
        for (int c = 0; c < 80 && !seen; c++) begin
            cycle(1);
            if (!busy) seen = 1;
        end
        chk("busy_clear_timeout", int'(seen), 1);
        chk("rise_level0", int'(dut.g_chan[0].u_chan.level), LMAX);
        for (int c = 0; c < 15; c++) begin
            cycle(1);
            chk("full_led", int'(led), 1);
        end

        // Mid-run asynchronous reset
        pio_in = 10'h3FF;
        repeat (20) cycle(1);
        reset_n = 1'b0;
        #1;
        chk("arst_led", int'(led), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_level", int'(dut.g_chan[0].u_chan.level), 0);
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (10) cycle(1);

        // Steady-state patterns
        for (int v = 0; v < 6; v++) begin
            pio_in = vecs[v].pat;
            repeat (vecs[v].hold) cycle(1);
            chk("vec_led", int'(led), int'(vecs[v].exp_led));
            chk("vec_busy", int'(busy), int'(vecs[v].exp_busy));
        end

        // Reversal at level 8
        pio_in = 10'h001;
        seen = 0;
        for (int c = 0; c < 60 && !seen; c++) begin
            cycle(1);
            if (m_level[0] == 8) seen = 1;
        end
        chk("rev_reach8", int'(seen), 1);
        pio_in = 10'h000;
        cycle(1);
        chk("rev_busy_mid", int'(busy), 1);
        seen = 0;
        for (int c = 0; c < 60 && !seen; c++) begin
            cycle(1);
            if (!busy) seen = 1;
        end
        chk("rev_done", int'(seen), 1);
        chk("rev_level0", int'(dut.g_chan[0].u_chan.level), 0);

        // All channels together
        pio_in = 10'h3FF;
        for (int c = 0; c < 80; c++) begin
            cycle(1);
            chk("lockstep", int'(led == '0 || led == '1), 1);
        end
        pio_in = 10'h000;
        repeat (80) cycle(1);

        // Randomised patterns, including short glitches
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(7, 0) == 0) pio_in = N'($urandom);
            cycle(1);
        end

        // Frozen levels: count PWM high cycles over one full period
        pio_in = 10'h001;
        for (int f = 0; f < 4; f++) begin
            force dut.g_chan[0].u_chan.level = fvecs[f].lvl;
            repeat (3) cycle(0);
            cnt = 0;
            for (int c = 0; c < LMAX; c++) begin
                cycle(0);
                if (led[0]) cnt++;
            end
            chk("pwm_high_count", cnt, fvecs[f].exp_high);
            release dut.g_chan[0].u_chan.level;
        end
        pulse_reset();
        pio_in = 10'h000;
        repeat (5) cycle(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
